dma_reg_xfer_ctrl: RTL
======================

# dma_reg_xfer_ctrl

Register-mapped DMA control block. It sits directly downstream of the DMA register bus and decodes `wr_en`/`rd_en`/`addr`/`wdata` into a small register file, returning `rdata`. A programmed START launches a word-transfer engine that issues source/destination address pairs on a req/ack handshake and reports completion via STATUS and a level interrupt.

## Interface
- `BASE_ADDR`, default 32'h0000_0400: byte address of the CTRL register; all others are offsets from it.
- `LEN_W`, default 16: width of the LENGTH and remaining-count fields.

- `clk`  in  1  single clock; all logic on posedge.
- `rst_n`  in  1  asynchronous active-low reset.
- `wr_en`  in  1  register write strobe, one write per cycle.
- `rd_en`  in  1  register read strobe.
- `addr`  in  32  byte address; only word-aligned addresses decode.
- `wdata`  in  32  write data.
- `rdata`  out  32  registered read data.
- `xfer_req`  out  1  engine request; a word pair is pending.
- `xfer_ack`  in  1  consumer accepts the current word when high with `xfer_req`.
- `xfer_src`  out  32  source byte address of the current word.
- `xfer_dst`  out  32  destination byte address of the current word.
- `irq`  out  1  level interrupt.

## Operation
- Register map, as offsets from BASE_ADDR:
  - +0x00 CTRL: [0] START, write-1 pulse, reads 0; [1] IRQ_EN, RW; [2] ABORT, write-1 pulse, reads 0.
  - +0x04 SRC_ADDR, RW 32. +0x08 DST_ADDR, RW 32.
  - +0x0C LENGTH, RW [LEN_W-1:0], in words; upper bits read 0.
  - +0x10 STATUS: [0] BUSY, RO; [1] DONE, sticky, W1C; [2] ERR, sticky, W1C; [31:16] REMAINING, RO.
  - +0x14 XFER_COUNT: RO, total words acked since reset, 32-bit, wraps.
- Unmapped or unaligned address: reads return 0; writes are ignored and set ERR.
- While BUSY:
  - Writes to SRC_ADDR, DST_ADDR and LENGTH are ignored and set ERR.
  - START is ignored and sets ERR.
- FSM states are IDLE, XFER and DONE.
  - IDLE, START written with LENGTH≠0: load the working source, destination and remaining registers from SRC_ADDR, DST_ADDR and LENGTH, then go to XFER.
  - IDLE, START written with LENGTH=0: go straight to DONE with no request.
  - XFER: `xfer_req`=1. On `xfer_ack`: source and destination each advance by 4 (mod 2^32), REMAINING decrements, XFER_COUNT increments. When the ack lands with REMAINING=1, go to DONE.
  - XFER, ABORT written: go to IDLE and set ERR. DONE is not set. An ack in the same cycle still counts.
  - DONE: set STATUS.DONE and go to IDLE.
- BUSY = (state ≠ IDLE).
- Programmed SRC_ADDR, DST_ADDR and LENGTH are never modified by the engine.
- `irq` = registered (STATUS.DONE & CTRL.IRQ_EN). It stays high until DONE is cleared or IRQ_EN is cleared.
- A W1C write to DONE in the same cycle the engine sets DONE leaves DONE=1 (set wins).

## Timing
- Writes take effect at the sampling posedge and are visible to reads issued on the next cycle.
- Reads: `rd_en` is sampled at edge N and `rdata` is valid after edge N. `rdata` holds its value when `rd_en`=0.
- Simultaneous `wr_en`/`rd_en` to the same address: the read returns the pre-write value.
- START write at edge N:
  - `xfer_req`=1 after edge N.
  - The first ack is possible at edge N+1.
  - After the final ack at edge M: state is DONE after M, STATUS.DONE=1 and BUSY=0 after M+1, `irq` after M+2.
- Sustained `xfer_ack`=1 gives one word per cycle. `xfer_src`/`xfer_dst` are stable while `xfer_req`=1 and ack=0.
- Reset values: all registers 0, state IDLE, `rdata`=0, `xfer_req`=0, `xfer_src`=0, `xfer_dst`=0, `irq`=0.
- Asserting `rst_n` mid-transfer aborts immediately with no further requests.

## Configuration
- `DMA_REG_XFER_COUNT_EN`:
  - Defined: the XFER_COUNT register and its counter are built.
  - Undefined: no counter is built. +0x14 reads 0, writes to it are ignored, and ERR is not set (the address stays mapped).

## Test plan
- Reset, then read every register → all 0, `irq`=0, `xfer_req`=0.
- Write SRC=0x1000, DST=0x2000, LENGTH=3, CTRL=0x3; ack every cycle → pairs (0x1000,0x2000), (0x1004,0x2004), (0x1008,0x2008). STATUS reads 0x2 two cycles after the last ack; `irq`=1 one cycle later; XFER_COUNT=3.
- Write STATUS=0x2 → DONE clears and `irq` drops one cycle after. Then START with LENGTH=0 → DONE=1 with no `xfer_req` pulse.
- LENGTH=5, START, ack twice, then write ABORT → STATUS=0x4 (ERR, not DONE, not BUSY) with REMAINING=3 in [31:16]; `xfer_req` low.
- While BUSY: write LENGTH=9 and START → LENGTH unchanged and ERR set. A read of 0x500 returns 0; a write to 0x500 sets ERR.
- Pull `rst_n` low mid-transfer → outputs 0 asynchronously. Without `DMA_REG_XFER_COUNT_EN`, +0x14 reads 0 after the transfer.

Source files
------------

// File: rtl/dma_reg_xfer_ctrl.sv
// dma_reg_xfer_ctrl
// Register-mapped DMA control block. Decodes the register bus into a small
// register file (CTRL, SRC_ADDR, DST_ADDR, LENGTH, STATUS, XFER_COUNT) and
// runs a word-transfer engine that presents source/destination address
// pairs on a req/ack handshake. Completion is reported through sticky
// STATUS.DONE and a registered level interrupt.
//
// Build option: define DMA_REG_XFER_COUNT_EN to build the XFER_COUNT
// register and its counter. Without it, +0x14 stays mapped but reads 0 and
// ignores writes.

module dma_reg_xfer_ctrl #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0400,
  parameter int unsigned LEN_W     = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wr_en,
  input  logic        rd_en,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        xfer_req,
  input  logic        xfer_ack,
  output logic [31:0] xfer_src,
  output logic [31:0] xfer_dst,
  output logic        irq
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_XFER = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t state;
  state_t state_next;

  // Programmed registers (never touched by the engine)
  logic [31:0]      src_reg;
  logic [31:0]      dst_reg;
  logic [LEN_W-1:0] len_reg;
  logic             irq_en;

  // Engine working copies
  logic [31:0]      work_src;
  logic [31:0]      work_dst;
  logic [LEN_W-1:0] remaining;

  // Sticky status flags
  logic done_flag;
  logic err_flag;

  // Address decode
  logic sel_ctrl, sel_src, sel_dst, sel_len, sel_stat, sel_cnt, mapped;
  logic wr_ctrl, wr_src, wr_dst, wr_len, wr_stat;

  // Control strobes
  logic start_cmd, abort_cmd, busy, ack_fire;
  logic load_work, set_done, abort_err;
  logic err_set, done_clr, err_clr;

  logic [31:0] rd_val;
  logic [31:0] count_rd;

  // Exact-match decode; unaligned addresses can never equal a register address
  assign sel_ctrl = (addr == BASE_ADDR);
  assign sel_src  = (addr == BASE_ADDR + 32'h04);
  assign sel_dst  = (addr == BASE_ADDR + 32'h08);
  assign sel_len  = (addr == BASE_ADDR + 32'h0C);
  assign sel_stat = (addr == BASE_ADDR + 32'h10);
  assign sel_cnt  = (addr == BASE_ADDR + 32'h14);
  assign mapped   = sel_ctrl | sel_src | sel_dst | sel_len | sel_stat | sel_cnt;

  assign wr_ctrl = wr_en & sel_ctrl;
  assign wr_src  = wr_en & sel_src;
  assign wr_dst  = wr_en & sel_dst;
  assign wr_len  = wr_en & sel_len;
  assign wr_stat = wr_en & sel_stat;

  assign start_cmd = wr_ctrl & wdata[0];
  assign abort_cmd = wr_ctrl & wdata[2];
  assign busy      = (state != ST_IDLE);
  assign ack_fire  = (state == ST_XFER) & xfer_ack;

  assign done_clr = wr_stat & wdata[1];
  assign err_clr  = wr_stat & wdata[2];

  // Illegal accesses: unmapped writes, config writes or START while busy, abort
  assign err_set = abort_err
                 | (wr_en & ~mapped)
                 | (busy & (wr_src | wr_dst | wr_len | start_cmd));

  assign xfer_req = (state == ST_XFER);
  assign xfer_src = work_src;
  assign xfer_dst = work_dst;

  // Next-state logic; the working registers are loaded on every accepted
  // START so REMAINING reads 0 after a zero-length transfer completes
  always_comb begin
    state_next = state;
    load_work  = 1'b0;
    set_done   = 1'b0;
    abort_err  = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (start_cmd) begin
          load_work = 1'b1;
          if (len_reg != '0) begin
            state_next = ST_XFER;
          end else begin
            state_next = ST_DONE;
          end
        end
      end
      ST_XFER: begin
        if (abort_cmd) begin
          abort_err  = 1'b1;
          state_next = ST_IDLE;
        end else if (ack_fire && (remaining == LEN_W'(1))) begin
          state_next = ST_DONE;
        end
      end
      ST_DONE: begin
        set_done   = 1'b1;
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Programmed configuration registers; config writes are dropped while busy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      src_reg <= 32'd0;
      dst_reg <= 32'd0;
      len_reg <= '0;
      irq_en  <= 1'b0;
    end else begin
      if (wr_src && !busy) begin
        src_reg <= wdata;
      end
      if (wr_dst && !busy) begin
        dst_reg <= wdata;
      end
      if (wr_len && !busy) begin
        len_reg <= wdata[LEN_W-1:0];
      end
      if (wr_ctrl) begin
        irq_en <= wdata[1];
      end
    end
  end

  // Working address/count registers advance one word per accepted handshake
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      work_src  <= 32'd0;
      work_dst  <= 32'd0;
      remaining <= '0;
    end else if (load_work) begin
      work_src  <= src_reg;
      work_dst  <= dst_reg;
      remaining <= len_reg;
    end else if (ack_fire) begin
      work_src  <= work_src + 32'd4;
      work_dst  <= work_dst + 32'd4;
      remaining <= remaining - LEN_W'(1);
    end
  end

  // Sticky DONE/ERR flags; a set in the same cycle as a W1C clear wins
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done_flag <= 1'b0;
      err_flag  <= 1'b0;
    end else begin
      if (set_done) begin
        done_flag <= 1'b1;
      end else if (done_clr) begin
        done_flag <= 1'b0;
      end
      if (err_set) begin
        err_flag <= 1'b1;
      end else if (err_clr) begin
        err_flag <= 1'b0;
      end
    end
  end

  // Level interrupt, registered from the current DONE and IRQ_EN state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      irq <= 1'b0;
    end else begin
      irq <= done_flag & irq_en;
    end
  end

`ifdef DMA_REG_XFER_COUNT_EN
  logic [31:0] xfer_count;

  // Running total of accepted words since reset, wraps at 2^32
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      xfer_count <= 32'd0;
    end else if (ack_fire) begin
      xfer_count <= xfer_count + 32'd1;
    end
  end

  assign count_rd = xfer_count;
`else
  assign count_rd = 32'd0;
`endif

  // Read mux built from pre-write register values
  always_comb begin
    rd_val = 32'd0;
    if (sel_ctrl) begin
      rd_val = {30'd0, irq_en, 1'b0};
    end else if (sel_src) begin
      rd_val = src_reg;
    end else if (sel_dst) begin
      rd_val = dst_reg;
    end else if (sel_len) begin
      rd_val = 32'(len_reg);
    end else if (sel_stat) begin
      rd_val = {16'(remaining), 13'd0, err_flag, done_flag, busy};
    end else if (sel_cnt) begin
      rd_val = count_rd;
    end
  end

  // Registered read data, held when no read is issued
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata <= 32'd0;
    end else if (rd_en) begin
      rdata <= rd_val;
    end
  end

endmodule
